// File: rtl/gmux_quad_ctrl_pkg.sv
// Shared types and constants for the quadrant global-clock-mux enable controller.
package gmux_quad_ctrl_pkg;

  localparam int unsigned NUM_QUAD  = 4;
  localparam int unsigned QUAD_IDX_W = 2;
  localparam int unsigned CNT_W     = 4;

  localparam int unsigned QUAD_TL = 0;
  localparam int unsigned QUAD_TR = 1;
  localparam int unsigned QUAD_BL = 2;
  localparam int unsigned QUAD_BR = 3;

  typedef enum logic [2:0] {
    ST_SLEEP = 3'd0,
    ST_WAKE  = 3'd1,
    ST_SYNC  = 3'd2,
    ST_ON    = 3'd3,
    ST_DRAIN = 3'd4,
    ST_IDLE  = 3'd5
  } quad_state_e;

  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [QUAD_IDX_W-1:0] quad_idx_t;

  // Per-quadrant enable bundle driven toward the global clock mux.
  typedef struct packed {
    logic den;
    logic dynen;
    logic sen;
    logic vlp;
    logic ack;
  } quad_ctl_t;

  localparam quad_ctl_t CTL_RESET = '{den: 1'b0, dynen: 1'b0, sen: 1'b0, vlp: 1'b1, ack: 1'b0};

  function automatic logic is_busy_state(input quad_state_e s);
    return (s == ST_WAKE) || (s == ST_SYNC) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/gmux_quad_ctrl_if.sv
// Request/enable bus between the quadrant controller and its requester / clock mux.
interface gmux_quad_ctrl_if;
  import gmux_quad_ctrl_pkg::*;

  logic [NUM_QUAD-1:0] req_en;
  logic [NUM_QUAD-1:0] req_vlp;
  logic [NUM_QUAD-1:0] dyn_mode;
  logic [NUM_QUAD-1:0] den;
  logic [NUM_QUAD-1:0] dynen;
  logic [NUM_QUAD-1:0] sen;
  logic [NUM_QUAD-1:0] vlp;
  logic [NUM_QUAD-1:0] ack;
  logic                busy;

  modport master (
    output req_en, req_vlp, dyn_mode,
    input  den, dynen, sen, vlp, ack, busy
  );

  modport slave (
    input  req_en, req_vlp, dyn_mode,
    output den, dynen, sen, vlp, ack, busy
  );
endinterface

// File: rtl/gmux_quad_ctrl_fsm.sv
// One quadrant's power-state FSM; outputs are registered decodes of the next state.
module gmux_quad_fsm
  import gmux_quad_ctrl_pkg::*;
#(
  parameter int unsigned WAKE_CYC  = 4,
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_en,
  input  logic        req_vlp,
  input  logic        dyn_mode,
  input  logic        grant,
  output quad_state_e state,
  output quad_ctl_t   ctl,
  output logic        busy_nxt_c
);

  localparam cnt_t WAKE_LOAD  = CNT_W'(WAKE_CYC - 1);
  localparam cnt_t DRAIN_LOAD = CNT_W'(DRAIN_CYC - 1);

  quad_state_e state_nxt;
  cnt_t        cnt, cnt_nxt;
  logic        dyn_lat, dyn_lat_nxt;
  quad_ctl_t   ctl_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_SLEEP;
      cnt     <= '0;
      dyn_lat <= 1'b0;
      ctl     <= CTL_RESET;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      dyn_lat <= dyn_lat_nxt;
      ctl     <= ctl_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    dyn_lat_nxt = dyn_lat;
    ctl_nxt     = '0;

    case (state)
      ST_SLEEP: begin
        if (grant) begin
          state_nxt = ST_WAKE;
          cnt_nxt   = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (cnt == '0) state_nxt = req_en ? ST_SYNC : ST_IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      ST_SYNC: begin
        state_nxt   = ST_ON;
        dyn_lat_nxt = dyn_mode;
      end
      ST_ON: begin
        if (!req_en) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = DRAIN_LOAD;
        end
      end
      // req_en is not a wake source here; VLP only counts with enable low.
      ST_DRAIN: begin
        if (cnt == '0) state_nxt = (req_vlp && !req_en) ? ST_SLEEP : ST_IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      ST_IDLE: begin
        if (req_en)       state_nxt = ST_SYNC;
        else if (req_vlp) state_nxt = ST_SLEEP;
      end
      default: state_nxt = ST_SLEEP;
    endcase

    case (state_nxt)
      ST_SLEEP: ctl_nxt.vlp = 1'b1;
      ST_SYNC:  ctl_nxt.sen = 1'b1;
      ST_ON: begin
        ctl_nxt.den   = 1'b1;
        ctl_nxt.ack   = 1'b1;
        ctl_nxt.dynen = dyn_lat_nxt;
      end
      default: ctl_nxt = '0;
    endcase

    busy_nxt_c = is_busy_state(state_nxt);
  end

endmodule

// File: rtl/gmux_quad_ctrl.sv
// Four quadrant FSMs sharing a round-robin wake grant that allows one WAKE at a time.
module gmux_quad_ctrl
  import gmux_quad_ctrl_pkg::*;
#(
  parameter int unsigned WAKE_CYC  = 4,
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  gmux_quad_ctrl_if.slave   bus
);

  quad_state_e         state [NUM_QUAD];
  quad_ctl_t           ctl   [NUM_QUAD];
  logic [NUM_QUAD-1:0] busy_nxt_c;
  logic [NUM_QUAD-1:0] sleep_req_c;
  logic [NUM_QUAD-1:0] grant_c;
  logic                any_wake_c;
  logic                grant_vld_c;
  quad_idx_t           gnt_idx_c;
  quad_idx_t           ptr;
  logic                busy;

  logic [NUM_QUAD-1:0] den_c, dynen_c, sen_c, vlp_c, ack_c;

  for (genvar i = 0; i < NUM_QUAD; i++) begin : g_quad
    gmux_quad_fsm #(
      .WAKE_CYC  (WAKE_CYC),
      .DRAIN_CYC (DRAIN_CYC)
    ) u_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_en     (bus.req_en[i]),
      .req_vlp    (bus.req_vlp[i]),
      .dyn_mode   (bus.dyn_mode[i]),
      .grant      (grant_c[i]),
      .state      (state[i]),
      .ctl        (ctl[i]),
      .busy_nxt_c (busy_nxt_c[i])
    );
  end

  always_comb begin
    any_wake_c  = 1'b0;
    sleep_req_c = '0;
    for (int i = 0; i < NUM_QUAD; i++) begin
      if (state[i] == ST_WAKE) any_wake_c = 1'b1;
      sleep_req_c[i] = (state[i] == ST_SLEEP) && bus.req_en[i];
    end
  end

  // Scan from ptr downward in offset so the nearest requester at or after ptr wins.
  always_comb begin
    gnt_idx_c   = ptr;
    grant_vld_c = 1'b0;
    for (int k = NUM_QUAD - 1; k >= 0; k--) begin
      if (sleep_req_c[QUAD_IDX_W'(ptr + QUAD_IDX_W'(k))]) begin
        gnt_idx_c   = QUAD_IDX_W'(ptr + QUAD_IDX_W'(k));
        grant_vld_c = 1'b1;
      end
    end
    grant_vld_c = grant_vld_c && !any_wake_c;
    grant_c     = '0;
    if (grant_vld_c) grant_c[gnt_idx_c] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= QUAD_IDX_W'(QUAD_TL);
      busy <= 1'b0;
    end else begin
      if (grant_vld_c) ptr <= QUAD_IDX_W'(gnt_idx_c + QUAD_IDX_W'(1));
      busy <= |busy_nxt_c;
    end
  end

  always_comb begin
    den_c   = '0;
    dynen_c = '0;
    sen_c   = '0;
    vlp_c   = '0;
    ack_c   = '0;
    for (int i = 0; i < NUM_QUAD; i++) begin
      den_c[i]   = ctl[i].den;
      dynen_c[i] = ctl[i].dynen;
      sen_c[i]   = ctl[i].sen;
      vlp_c[i]   = ctl[i].vlp;
      ack_c[i]   = ctl[i].ack;
    end
  end

  assign bus.den   = den_c;
  assign bus.dynen = dynen_c;
  assign bus.sen   = sen_c;
  assign bus.vlp   = vlp_c;
  assign bus.ack   = ack_c;
  assign bus.busy  = busy;

endmodule

// File: doc/gmux_quad_ctrl.md
GMUX_QUAD_CTRL -- requirements
Module: gmux_quad_ctrl

Interface
REQ-001 Parameter WAKE_CYC, default 4, SHALL set the cycles spent in WAKE; legal range 1..15.
REQ-002 Parameter DRAIN_CYC, default 2, SHALL set the cycles spent in DRAIN; legal range 1..15.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 RST_N  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 REQ_EN  input  4  SHALL carry per-quadrant enable requests, index 0=TL, 1=TR, 2=BL, 3=BR (same indexing for all 4-bit ports).
REQ-006 REQ_VLP  input  4  SHALL carry per-quadrant very-low-power requests, honoured only when that quadrant's REQ_EN=0.
REQ-007 DYN_MODE  input  4  SHALL carry per-quadrant dynamic-enable selects.
REQ-008 DEN, DYNEN, SEN, VLP  output  4 each  SHALL drive the quadrant enable controls consumed by the global clock mux.
REQ-009 ACK  output  4  SHALL be high while the quadrant is in ON.
REQ-010 BUSY  output  1  SHALL be high while any quadrant is in WAKE, SYNC or DRAIN.

Function
REQ-011 Each quadrant SHALL run an independent FSM with states SLEEP, WAKE, SYNC, ON, DRAIN, IDLE.
REQ-012 All outputs SHALL be registered Moore functions of state: SLEEP VLP=1; WAKE all 0; SYNC SEN=1; ON DEN=1, DYNEN=latched DYN_MODE, ACK=1; DRAIN all 0; IDLE all 0.
REQ-013 SLEEP->WAKE SHALL occur when REQ_EN=1 and that quadrant holds the wake grant; the counter loads WAKE_CYC-1.
REQ-014 WAKE SHALL decrement the counter each cycle and exit at count 0: to SYNC if REQ_EN=1, otherwise to IDLE.
REQ-015 SYNC SHALL last exactly 1 cycle, latch DYN_MODE, and go to ON unconditionally.
REQ-016 ON SHALL hold while REQ_EN=1; on REQ_EN=0 it SHALL go to DRAIN with the counter loaded to DRAIN_CYC-1.
REQ-017 DRAIN SHALL count down to 0, then go to SLEEP if REQ_VLP=1, else IDLE; REQ_EN during DRAIN SHALL be ignored until DRAIN exits.
REQ-018 IDLE SHALL go to SYNC on REQ_EN=1 without a grant, and to SLEEP on REQ_VLP=1 with REQ_EN=0; REQ_EN SHALL win if both are high.
REQ-019 Latency SHALL be as follows: from the edge entering WAKE, ACK rises WAKE_CYC+1 edges later; from IDLE with REQ_EN=1, ACK rises 2 edges later.
REQ-020 At most one quadrant SHALL be in WAKE at any time (inrush limit).
REQ-021 The wake grant SHALL be issued round-robin among quadrants in SLEEP with REQ_EN=1.
REQ-022 The round-robin pointer SHALL advance to the index after the granted quadrant; from reset the pointer starts at 0.
REQ-023 No grant SHALL be issued while any quadrant is in WAKE.
REQ-024 SEN SHALL never be high in the same cycle as DEN for the same quadrant.
REQ-025 DEN SHALL never be high while VLP is high for the same quadrant.

Reset
REQ-026 RST_N=0 SHALL immediately force all FSMs to SLEEP, counters and pointer to 0, VLP=4'hF, and all other outputs to 0, including mid-WAKE or mid-ON.
REQ-027 After RST_N deasserts, the first state change SHALL occur on the next rising CLK edge.

Structure
REQ-028 A shared package SHALL hold the state enumeration, quadrant index constants (TL/TR/BL/BR) and counter width (4).
REQ-029 Per-quadrant logic SHALL be one sub-module, gmux_quad_fsm, instantiated 4 times.
REQ-030 The arbiter and BUSY logic SHALL live in the top level.

Verification (WAKE_CYC=4, DRAIN_CYC=2)
REQ-031 Reset, then REQ_EN=4'b0001 at edge 0 -> TL enters WAKE at edge 1, SEN[0]=1 during edge 5-6, ACK[0]/DEN[0] high from edge 6, VLP[0]=0 from edge 1.
REQ-032 REQ_EN=4'b1111 in one cycle from SLEEP -> WAKE grants in order TL, TR, BL, BR, each 5 cycles apart; BUSY high throughout.
REQ-033 In ON, drop REQ_EN[0] with REQ_VLP[0]=1 -> DEN[0]=0 next edge, 2 DRAIN cycles, then VLP[0]=1.
REQ-034 In IDLE, raise REQ_EN[2] and REQ_VLP[2] together -> SYNC then ON in 2 edges; VLP[2] stays 0.
REQ-035 Drop REQ_EN[1] during WAKE -> WAKE completes 4 cycles, goes to IDLE, SEN[1] never asserts.
REQ-036 Assert RST_N=0 asynchronously mid-ON -> outputs reach reset values without a clock edge; all ACK=0.
